// File: rtl/parity_uart_tx.sv
// UART-style serial transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// One byte is accepted over a valid/ready handshake whenever the line is idle.
module parity_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic PAR_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Handshake: a byte transfers on a rising edge where valid && ready; ready is
    // high only in IDLE, and valid while busy is dropped, never queued.
    state_t           state, state_next;
    logic [DIV_W-1:0] div, div_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             par_bit, par_next;
    logic             tx_next;
    logic             bit_done;

    assign bit_done = (div == DIV_LAST);
    assign ready    = (state == IDLE);
    assign busy     = ~ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            div       <= div_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            par_bit   <= par_next;
            tx        <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        div_next     = div;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        par_next     = par_bit;
        tx_next      = 1'b1;

        if (state != IDLE) begin
            div_next = bit_done ? '0 : div + 1'b1;
        end

        case (state)
            IDLE: begin
                if (valid) begin
                    state_next   = START;
                    shift_next   = data_in;
                    par_next     = (^data_in) ^ PAR_INV;
                    div_next     = '0;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = PAR;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            PAR: begin
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                if (bit_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // tx is registered, so it is decoded from the state being entered.
        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PAR:     tx_next = par_next;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_parity_uart_tx.sv
// Bench for parity_uart_tx: three instances (4 clk/bit even, 4 clk/bit odd, 1 clk/bit even)
// checked every cycle against a frame-position model, plus hand-computed frame literals.
module tb_parity_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_r [3];
    logic [2:0] valid_r = '0;
    logic [2:0] tx_w, ready_w, busy_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        parity_uart_tx #(
            .CLKS_PER_BIT(g == 2 ? 1 : 4),
            .PARITY_ODD  (g == 1 ? 1 : 0)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .data_in(data_r[g]),
            .valid  (valid_r[g]),
            .ready  (ready_w[g]),
            .tx     (tx_w[g]),
            .busy   (busy_w[g])
        );
    end

    function automatic int cpb_of(input int ch);
        return (ch == 2) ? 1 : 4;
    endfunction

    function automatic logic odd_of(input int ch);
        return (ch == 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is just 11 bits, each held cpb cycles; pos counts cycles into it.
    int         pos [3] = '{-1, -1, -1};
    logic [10:0] frm [3];
    bit         started = 0;

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            for (int ch = 0; ch < 3; ch++) pos[ch] = -1;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                if (pos[ch] < 0) begin
                    if (valid_r[ch]) begin
                        frm[ch] = {1'b1, 1'(($countones(data_r[ch]) % 2) != 0) ^ odd_of(ch),
                                   data_r[ch], 1'b0};
                        pos[ch] = 0;
                    end
                end else begin
                    pos[ch]++;
                    if (pos[ch] == 11 * cpb_of(ch)) pos[ch] = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int ch = 0; ch < 3; ch++) begin
                logic exp_tx;
                exp_tx = (pos[ch] < 0) ? 1'b1 : frm[ch][pos[ch] / cpb_of(ch)];
                check($sformatf("model_tx%0d", ch), 32'(tx_w[ch]), 32'(exp_tx));
                check($sformatf("model_ready%0d", ch), 32'(ready_w[ch]), 32'(pos[ch] < 0));
                check($sformatf("model_busy%0d", ch), 32'(busy_w[ch]), 32'(pos[ch] >= 0));
            end
        end
    end

    logic cap [0:127];
    logic rdy_cap [0:127];

    // Called at a negedge; leaves valid high after the accept edge so callers may hold it.
    task automatic send_hold(input int ch, input logic [7:0] d);
        int k = 0;
        while (pos[ch] >= 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check($sformatf("idle_timeout%0d", ch), 32'd1, 32'd0);
        data_r[ch]  = d;
        valid_r[ch] = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input int ch, input logic [7:0] d);
        send_hold(ch, d);
        valid_r[ch] = 1'b0;
    endtask

    // Sample i is the i-th negedge after the accept edge; optional valid pulse/drop.
    task automatic capture(input int ch, input int n, input int set_idx,
                           input logic [7:0] set_data, input int clr_idx);
        for (int i = 0; i < n; i++) begin
            if (i == set_idx) begin
                data_r[ch]  = set_data;
                valid_r[ch] = 1'b1;
            end
            if (i == clr_idx) valid_r[ch] = 1'b0;
            cap[i]     = tx_w[ch];
            rdy_cap[i] = ready_w[ch];
            if (i < n - 1) @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input int base, input int cpb,
                               input logic [10:0] f);
        int bad = -1;
        for (int b = 0; b < 11; b++)
            for (int c = 0; c < cpb; c++)
                if (bad < 0 && cap[base + b * cpb + c] !== f[b]) bad = b * cpb + c;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: sample %0d got %b expected %b", name, bad, cap[base + bad],
                     f[bad / cpb]);
        end
    endtask

    initial begin
        for (int ch = 0; ch < 3; ch++) data_r[ch] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_tx", 32'(tx_w), 32'h7);
        check("reset_ready", 32'(ready_w), 32'h7);
        check("reset_busy", 32'(busy_w), 32'h0);

        // 1: 0xA5, even parity, 4 clocks per bit
        send(0, 8'hA5);
        capture(0, 46, -1, 8'h00, -1);
        check("a5_ready_drop", 32'(rdy_cap[0]), 32'd0);
        check_frame("a5_frame", 0, 4, 11'b1_0_10100101_0);
        check("a5_ready_43", 32'(rdy_cap[43]), 32'd0);
        check("a5_ready_44", 32'(rdy_cap[44]), 32'd1);

        // 2: parity modes; parity bit sits in samples 36..39
        send(0, 8'h07); capture(0, 45, -1, 8'h00, -1); check("par07_even", 32'(cap[37]), 32'd1);
        send(1, 8'h07); capture(1, 45, -1, 8'h00, -1); check("par07_odd", 32'(cap[37]), 32'd0);
        send(0, 8'h00); capture(0, 45, -1, 8'h00, -1); check("par00_even", 32'(cap[37]), 32'd0);
        send(1, 8'h00); capture(1, 45, -1, 8'h00, -1); check("par00_odd", 32'(cap[37]), 32'd1);
        send(0, 8'hFF); capture(0, 45, -1, 8'h00, -1); check("parff_even", 32'(cap[37]), 32'd0);
        send(1, 8'hFF); capture(1, 45, -1, 8'h00, -1); check("parff_odd", 32'(cap[37]), 32'd1);
        check_frame("ff_odd_frame", 0, 4, 11'b1_1_11111111_0);

        // 3: valid held, back-to-back 0x3C then 0xC3
        send_hold(0, 8'h3C);
        capture(0, 90, 0, 8'hC3, 45);
        check_frame("b2b_frame1", 0, 4, 11'b1_0_00111100_0);
        check("b2b_idle_tx", 32'(cap[44]), 32'd1);
        check("b2b_idle_ready", 32'(rdy_cap[44]), 32'd1);
        check("b2b_start2", 32'(cap[45]), 32'd0);
        check_frame("b2b_frame2", 45, 4, 11'b1_0_11000011_0);

        // 4: valid pulse with 0x55 mid-frame is dropped
        send(0, 8'h0F);
        capture(0, 55, 20, 8'h55, 21);
        check_frame("busy_frame_0f", 0, 4, 11'b1_0_00001111_0);
        check("busy_no_55_tx", 32'(cap[54]), 32'd1);
        check("busy_no_55_ready", 32'(rdy_cap[54]), 32'd1);

        // 5: reset during data bit 3 of 0xF0, then a fresh frame
        send(0, 8'hF0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", 32'(tx_w[0]), 32'd1);
        check("midrst_ready", 32'(ready_w[0]), 32'd1);
        check("midrst_busy", 32'(busy_w[0]), 32'd0);
        send(0, 8'h81);
        capture(0, 45, -1, 8'h00, -1);
        check_frame("post_rst_81", 0, 4, 11'b1_0_10000001_0);

        // 6: one clock per bit
        send(2, 8'h96);
        capture(2, 12, -1, 8'h00, -1);
        check_frame("cpb1_96", 0, 1, 11'b1_0_10010110_0);
        check("cpb1_ready_10", 32'(rdy_cap[10]), 32'd0);
        check("cpb1_ready_11", 32'(rdy_cap[11]), 32'd1);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
